prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the instruction-memory word-address width (4096 words).
REQ-002 SHALL have parameter SYNC, default 8'hA5, meaning the frame start byte.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  byte-stream source has a byte.
REQ-006 SHALL have port in_data  input  8  byte-stream data.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high on a rising edge.
REQ-008 SHALL have port mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  word address.
REQ-010 SHALL have port mem_wdata  output  32  instruction word.
REQ-011 SHALL have port cpu_rst_n  output  1  active-low reset to the core.
REQ-012 SHALL have ports busy, done, error  output  1 each  load in progress, last load succeeded, last load failed.

Function
REQ-013 SHALL implement the frame: SYNC, LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes with each word least-significant byte first.
REQ-014 SHALL use the FSM states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE and ERR.
REQ-015 SHALL, in IDLE, DONE or ERR, enter LEN_LO on an accepted SYNC byte and silently discard any other accepted byte.
REQ-016 SHALL, when N is 0 or N > 2**ADDR_W, go from LEN_HI to ERR without any memory write.
REQ-017 SHALL drive in_ready high in every state; the loader never back-pressures.
REQ-018 SHALL pulse mem_we for exactly one cycle, starting the cycle after the fourth byte of a word is accepted.
REQ-019 SHALL hold mem_addr and mem_wdata stable while mem_we is high.
REQ-020 SHALL start mem_addr at 0 for each frame and increment it by 1 per word.
REQ-021 SHALL leave DATA after word N-1 is accepted; the word count never wraps.
REQ-022 SHALL register cpu_rst_n: low one cycle after entering LEN_LO, LEN_HI, DATA, CSUM or ERR, and high one cycle after entering IDLE or DONE.
REQ-023 SHALL drive busy high in LEN_LO, LEN_HI, DATA and CSUM; done high only in DONE; error high only in ERR.
REQ-024 SHALL restart the frame (enter LEN_LO) and discard the partial word when SYNC arrives mid-DATA.
REQ-025 SHALL sustain one byte per cycle with no bubbles.

Reset
REQ-026 SHALL, while rst_n is low, force the state to IDLE and all counters to 0.
REQ-027 SHALL drive the reset values mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, error=0 and in_ready=1.
REQ-028 SHALL, on rst_n asserted mid-frame, abandon the frame immediately, issue no further mem_we, and raise cpu_rst_n on the first clock edge after rst_n is released.

Configuration
REQ-029 SHALL, with PROG_LOADER_CHECKSUM_EN defined, follow the data with one CSUM byte equal to the XOR of all 4*N data bytes.
REQ-030 SHALL, with PROG_LOADER_CHECKSUM_EN defined, go from CSUM to DONE on a matching CSUM byte and to ERR on a mismatch; words already written stay written.
REQ-031 SHALL, without PROG_LOADER_CHECKSUM_EN, omit the CSUM state and go from DATA directly to DONE.

Structure
REQ-032 SHALL place the state enum type, the SYNC default and the ADDR_W default in package prog_loader_pkg.
REQ-033 SHALL implement byte-to-word packing (byte lane counter plus shift register) in sub-module word_packer.

Verification
REQ-034 SHALL cover: no checksum; bytes A5 02 00 13 00 10 00 93 00 20 00 -> mem_we at addr 0 data 00100013, at addr 1 data 00200093, then done=1 and cpu_rst_n=1.
REQ-035 SHALL cover: bytes A5 00 00 -> error=1, cpu_rst_n=0, no mem_we.
REQ-036 SHALL cover: bytes A5 01 00 11 22 A5 01 00 44 33 22 11 -> single write at addr 0 with data 11223344; the first partial word is discarded.
REQ-037 SHALL cover: checksum enabled; A5 01 00 01 02 03 04 04 -> done=1; same frame with checksum byte 05 -> error=1 and cpu_rst_n=0.
REQ-038 SHALL cover: rst_n pulsed low after 2 data bytes -> all outputs at their reset values and no mem_we; a following valid frame loads correctly.
REQ-039 SHALL cover: N=4096 with in_valid held high every cycle -> 4096 writes at addresses 0..4095 with no missed bytes, and no write beyond address 4095.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
// State encodings are kept as fixed constants so the register values match
// the legacy encoding; the enum is built on top of them.
package prog_loader_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 12;
   localparam logic [7:0]  SYNC_DEFAULT   = 8'hA5;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_LO = 3'd1;
   localparam logic [2:0] ST_LEN_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_CSUM   = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ERR    = 3'd6;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      LEN_LO = ST_LEN_LO,
      LEN_HI = ST_LEN_HI,
      DATA   = ST_DATA,
      CSUM   = ST_CSUM,
      DONE   = ST_DONE,
      ERR    = ST_ERR
   } state_t;

   // A frame is in flight in any of the header, payload or checksum states.
   function automatic logic is_busy(input state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/word_packer.sv
// Byte-to-word packer: collects four bytes LSB first and flags the
// cycle in which the fourth byte arrives, presenting the full word
// combinationally in that same cycle.
module word_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clr,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   output logic        o_word_done,
   output logic [31:0] o_word
);

   logic [1:0]  r_lane;
   logic [23:0] r_shift;

   // Lane counter and shift register; i_clr drops any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane  <= '0;
         r_shift <= '0;
      end else if (i_clr) begin
         r_lane  <= '0;
      end else if (i_valid) begin
         r_shift <= {i_data, r_shift[23:8]};
         r_lane  <= r_lane + 2'd1;
      end
   end

   assign o_word_done = i_valid && (r_lane == 2'd3);
   assign o_word      = {i_data, r_shift};

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses SYNC / LEN_LO / LEN_HI / payload frames from a byte
// stream and writes 32-bit words into instruction memory, holding the core
// in reset while a load is in progress.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte after the payload.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter logic [7:0]  SYNC   = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_t            r_state;
   logic [7:0]        r_len_lo;
   logic [15:0]       r_len;
   logic [ADDR_W-1:0] r_wcnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_cpu_rst_n;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        r_xor;
`endif

   logic        w_is_sync;
   logic [15:0] w_len;
   logic [31:0] w_len32;
   logic        w_len_bad;
   logic        w_last_word;
   logic        w_pk_valid;
   logic        w_pk_clr;
   logic        w_word_done;
   logic [31:0] w_word;

   assign w_is_sync   = (in_data == SYNC);
   assign w_len       = {in_data, r_len_lo};
   assign w_len32     = {16'd0, w_len};
   assign w_len_bad   = (w_len == 16'd0) || (w_len32 > (32'd1 << ADDR_W));
   // Word index compared as count+1 against N so the index never needs to
   // hold the value N itself and cannot wrap.
   assign w_last_word = ((32'(r_wcnt) + 32'd1) == {16'd0, r_len});

   // SYNC inside the payload restarts the frame, so it is never packed.
   assign w_pk_valid  = (r_state == DATA) && in_valid && !w_is_sync;
   assign w_pk_clr    = (r_state != DATA);

   word_packer u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (w_pk_clr),
      .i_valid     (w_pk_valid),
      .i_data      (in_data),
      .o_word_done (w_word_done),
      .o_word      (w_word)
   );

   // Frame parser: header capture, word counting and state transitions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_len_lo <= '0;
         r_len    <= '0;
         r_wcnt   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         r_xor    <= '0;
`endif
      end else if (in_valid) begin
         case (r_state)
            IDLE, DONE, ERR: begin
               if (w_is_sync) r_state <= LEN_LO;
            end
            LEN_LO: begin
               r_len_lo <= in_data;
               r_state  <= LEN_HI;
            end
            LEN_HI: begin
               r_len  <= w_len;
               r_wcnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               r_xor  <= '0;
`endif
               r_state <= w_len_bad ? ERR : DATA;
            end
            DATA: begin
               if (w_is_sync) begin
                  r_state <= LEN_LO;
               end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  r_xor <= r_xor ^ in_data;
`endif
                  if (w_word_done) begin
                     if (w_last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_state <= CSUM;
`else
                        r_state <= DONE;
`endif
                     end else begin
                        r_wcnt <= r_wcnt + ADDR_W'(1);
                     end
                  end
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
               r_state <= (in_data == r_xor) ? DONE : ERR;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   // Memory write port: one-cycle strobe with address/data held alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_word_done;
         if (w_word_done) begin
            r_addr  <= r_wcnt;
            r_wdata <= w_word;
         end
      end
   end

   // Core reset follows the state one cycle late.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_rst_n <= 1'b0;
      end else begin
         r_cpu_rst_n <= (r_state == IDLE) || (r_state == DONE);
      end
   end

   assign in_ready  = 1'b1;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign cpu_rst_n = r_cpu_rst_n;
   assign busy      = is_busy(r_state);
   assign done      = (r_state == DONE);
   assign error     = (r_state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard.
// Define PROG_LOADER_CHECKSUM_EN for both RTL and bench to cover the
// checksum build.
module tb_prog_loader;

   localparam int unsigned AW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_rst_n;
   logic          busy;
   logic          done;
   logic          error;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   wr_t  q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_writes = 0;
   int   w0;
   logic prev_we  = 1'b0;
   logic [7:0] big_xor;

   always #5 clk = ~clk;

   prog_loader #(.ADDR_W(AW), .SYNC(8'hA5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input int unsigned a, input logic [31:0] d);
      wr_t e;
      e.a = a[AW-1:0];
      e.d = d;
      q.push_back(e);
   endtask

   // One clock: let the edge happen, then sample and score any write.
   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      if (mem_we === 1'b1) begin
         n_writes++;
         chk("we_pulse_width", {63'd0, prev_we}, 64'd0);
         chk("wr_expected", {63'd0, q.size() != 0}, 64'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("wr_addr", {52'd0, mem_addr}, {52'd0, e.a});
            chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.d});
         end
      end
      prev_we = mem_we;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
   endtask

   // Checksum byte only exists in the checksum build.
   task automatic send_csum(input logic [7:0] b);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(b);
`else
      if (b == 8'h00) in_data = 8'h00;
`endif
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic status(input string tag, input logic b, input logic d,
                         input logic e, input logic c);
      chk({tag, "_busy"},      {63'd0, busy},      {63'd0, b});
      chk({tag, "_done"},      {63'd0, done},      {63'd0, d});
      chk({tag, "_error"},     {63'd0, error},     {63'd0, e});
      chk({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, {63'd0, c});
      chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
   endtask

   task automatic reset_values(input string tag);
      chk({tag, "_mem_we"},    {63'd0, mem_we},    64'd0);
      chk({tag, "_mem_addr"},  {52'd0, mem_addr},  64'd0);
      chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
      status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Power-on reset
      #1 rst_n = 1'b0;
      #2;
      reset_values("por");
      idle(2);
      reset_values("por_held");
      rst_n = 1'b1;
      idle(1);
      chk("por_release_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);

      // Two-word frame
      w0 = n_writes;
      expect_wr(0, 32'h00100013);
      expect_wr(1, 32'h00200093);
      send(8'hA5); send(8'h02);
      status("hdr", 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h00);
      send(8'h13); send(8'h00); send(8'h10); send(8'h00);
      send(8'h93); send(8'h00); send(8'h20); send(8'h00);
      send_csum(8'hB0);
      idle(2);
      status("two_words", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("two_words_count", 64'(n_writes - w0), 64'd2);

      // Zero length
      w0 = n_writes;
      send(8'hA5); send(8'h00); send(8'h00);
      idle(2);
      status("len0", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("len0_writes", 64'(n_writes - w0), 64'd0);

      // Length one beyond memory size
      w0 = n_writes;
      send(8'hA5); send(8'h01); send(8'h10);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      idle(2);
      status("len4097", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("len4097_writes", 64'(n_writes - w0), 64'd0);

      // SYNC mid-word restarts the frame
      w0 = n_writes;
      expect_wr(0, 32'h11223344);
      send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'h44); send(8'h33); send(8'h22); send(8'h11);
      send_csum(8'h44);
      idle(2);
      status("restart", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("restart_writes", 64'(n_writes - w0), 64'd1);

      // Checksum good/bad (plain build: frame ends after payload, stray byte ignored)
      expect_wr(0, 32'h04030201);
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h04);
      idle(2);
      status("csum_ok", 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
      expect_wr(0, 32'h04030201);
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h05);
      idle(2);
      status("csum_bad", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

      // Reset pulse in the middle of a payload
      w0 = n_writes;
      send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      reset_values("midrst");
      idle(1);
      reset_values("midrst_held");
      rst_n = 1'b1;
      idle(1);
      chk("midrst_release_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
      chk("midrst_writes", 64'(n_writes - w0), 64'd0);
      expect_wr(0, 32'h12345678);
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      send_csum(8'h08);
      idle(2);
      status("after_rst", 1'b0, 1'b1, 1'b0, 1'b1);

      // Full memory, back-to-back bytes
      w0 = n_writes;
      big_xor = 8'h00;
      send(8'hA5); send(8'h00); send(8'h10);
      for (int unsigned i = 0; i < 4096; i++) begin
         logic [11:0] v;
         v = i[11:0];
         expect_wr(i, {8'h3C, 4'h0, v[11:8], 4'h0, v[7:4], 4'h0, v[3:0]});
         big_xor = big_xor ^ {4'h0, v[3:0]} ^ {4'h0, v[7:4]} ^ {4'h0, v[11:8]} ^ 8'h3C;
         send({4'h0, v[3:0]});
         send({4'h0, v[7:4]});
         send({4'h0, v[11:8]});
         send(8'h3C);
      end
      send_csum(big_xor);
      for (int unsigned k = 0; k < 8; k++) send(8'h11);
      idle(2);
      status("full", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("full_writes", 64'(n_writes - w0), 64'd4096);
      chk("scoreboard_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
